data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port BIP data memory between two requesters: port 0 (CPU control/datapath)
//  and port 1 (debug/loader). Sits between the requesters and the data memory; arbitrates,
//  sequences each access through a small FSM and routes read data back to the winning port.
//  Data memory is synchronous: read data is valid the cycle after mem_rd.
// PARAMETERS
//  ADDR_W  11  data memory address width
//  DATA_W  16  data word width
// PORTS
//  clk         in   1       single clock for all logic
//  rst         in   1       synchronous, active-high reset
//  p0_req      in   1       port 0 access request; held with fields stable until p0_ready
//  p0_we       in   1       port 0: 1 = write, 0 = read
//  p0_addr     in   ADDR_W  port 0 address
//  p0_wdata    in   DATA_W  port 0 write data
//  p0_ready    out  1       1-cycle pulse: port 0 request consumed
//  p0_rvalid   out  1       1-cycle pulse: p0_rdata valid (reads only)
//  p0_rdata    out  DATA_W  port 0 read data; 0 when p0_rvalid=0
//  p1_*        same set as p0_* for port 1
//  mem_rd      out  1       data memory read strobe
//  mem_wr      out  1       data memory write strobe
//  mem_addr    out  ADDR_W  data memory address (registered)
//  mem_wdata   out  DATA_W  data memory write data (registered)
//  mem_rdata   in   DATA_W  data memory read data, valid cycle after mem_rd
//  owner       out  1       port of current/last grant
//  busy        out  1       1 when FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; rr pointer=0 (port 0 favoured first).
//  - FSM states: IDLE, ACCESS, RESP.
//  - IDLE: if any req, pick winner, latch addr/wdata/we/port into registers, owner<=winner, ->ACCESS.
//    No req: stay IDLE.
//  - ACCESS (1 cycle): mem_rd=~we_q or mem_wr=we_q, mem_addr/mem_wdata from latched regs;
//    pN_ready=1 for winner. Write -> IDLE; read -> RESP.
//  - RESP (1 cycle): pN_rvalid=1 for winner, pN_rdata=mem_rdata; -> IDLE.
//  - Latency from req in IDLE: write ready at T+1; read ready at T+1, rvalid at T+2.
//    Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
//  - Requests sampled only in IDLE; req changes in ACCESS/RESP are ignored until IDLE.
//  - Round robin: both req in IDLE -> grant port = rr pointer; after any grant pointer <= ~winner.
//    Single req is always granted regardless of pointer.
//  - Exactly one of mem_rd/mem_wr is high, only in ACCESS; never both.
//  - Exactly one of p0_ready/p1_ready is high, only in ACCESS.
//  - rst mid-operation: next cycle IDLE, strobes/ready/rvalid 0, pending response dropped,
//    pointer back to 0.
//  - Req dropped before ready: protocol violation; behaviour is undefined; bench flags it.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: port 0 always wins contention; rr pointer held at 0.
//  Not defined: round robin as above.
// STRUCTURE
//  Shared package bip_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=2'd0, ACCESS=2'd1,
//  RESP=2'd2), port index constants PORT_CPU=0, PORT_DBG=1.
//  One sub-module: rr_arbiter2 (2-way picker plus pointer register; honours ARB_FIXED_PRIO_EN).
//  FSM, request latches and response routing live in data_mem_arbiter.
// TESTING
//  1. p0 write addr=0x005 data=0xBEEF alone -> T+1: mem_wr=1, mem_addr=0x005,
//     mem_wdata=0xBEEF, p0_ready=1; busy 1 cycle.
//  2. p1 read addr=0x005 after test 1 (model returns 0xBEEF) -> T+1: mem_rd=1, p1_ready=1;
//     T+2: p1_rvalid=1, p1_rdata=0xBEEF; p0_rvalid=0, p0_rdata=0.
//  3. p0,p1 req together, held for 4 grants -> grant order 0,1,0,1 (round robin);
//     with ARB_FIXED_PRIO_EN -> 0,0,0,0 and p1 never gets a grant while p0 holds req.
//  4. rst in RESP of p0 read -> next cycle busy=0, p0_rvalid=0, no strobes;
//     next contention grants port 0 first.
//  5. Random mix of reads/writes from both ports vs reference memory model for 10k cycles ->
//     all read data match; mem_rd&mem_wr never both 1; one ready per granted request.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP definitions: default widths, arbiter FSM state encoding and port indices.
// The arbiter's fixed-priority build option is selected with ARB_FIXED_PRIO_EN.
package bip_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way request picker with a round-robin pointer.
// Build option ARB_FIXED_PRIO_EN: the pointer is held at 0, so port 0 always
// wins contention. The pick logic is the same in both builds.
module rr_arbiter2
  import bip_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_any,
  output logic o_winner
);

  logic r_ptr;
  logic w_winner;

  // Contention goes to the pointer; a lone request always wins.
  always_comb begin
    w_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      w_winner = r_ptr;
    end else if (i_req1) begin
      w_winner = PORT_DBG;
    end
  end

  // Pointer moves to the other port after every grant (held at 0 in fixed priority).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PORT_CPU;
    end else if (i_update && o_any) begin
`ifdef ARB_FIXED_PRIO_EN
      r_ptr <= PORT_CPU;
`else
      r_ptr <= ~w_winner;
`endif
    end
  end

  assign o_any    = i_req0 | i_req1;
  assign o_winner = w_winner;

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port synchronous data memory between the
// CPU port (0) and the debug/loader port (1). IDLE -> ACCESS -> (RESP) -> IDLE.
// Handshake: a requester holds pN_req with stable fields until it sees pN_ready
// high on a rising edge; that edge consumes the request. Read data follows as a
// one-cycle pN_rvalid pulse on the next cycle; pN_rdata is 0 outside that pulse.
// Build option ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins contention).
module data_mem_arbiter
  import bip_pkg::*;
#(
  parameter int ADDR_W = bip_pkg::ADDR_W,
  parameter int DATA_W = bip_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_we;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_any;
  logic                w_winner;
  logic                w_grant;

  // Requests are only looked at in IDLE; a grant there also advances the pointer.
  assign w_grant = (r_state == ST_IDLE) && w_any;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_update (w_grant),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: writes finish in ACCESS, reads take one more cycle for the data.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = r_we ? ST_IDLE : ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Latch the winning request; these registers drive the memory bus directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_owner <= PORT_CPU;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      r_we    <= (w_winner == PORT_DBG) ? p1_we    : p0_we;
      r_addr  <= (w_winner == PORT_DBG) ? p1_addr  : p0_addr;
      r_wdata <= (w_winner == PORT_DBG) ? p1_wdata : p0_wdata;
    end
  end

  // Strobes, handshakes and read-data routing, all decoded from state and owner.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    if (r_state == ST_ACCESS) begin
      mem_rd   = ~r_we;
      mem_wr   = r_we;
      p0_ready = (r_owner == PORT_CPU);
      p1_ready = (r_owner == PORT_DBG);
    end
    if (r_state == ST_RESP) begin
      if (r_owner == PORT_DBG) begin
        p1_rvalid = 1'b1;
        p1_rdata  = mem_rdata;
      end else begin
        p0_rvalid = 1'b1;
        p0_rdata  = mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign owner     = r_owner;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed table of single-port accesses,
// hand-written contention and mid-operation reset sequences, then a random
// two-port mix checked against a reference memory.
module tb_data_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_ready, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_ready, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          owner, busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic sb_en  = 1'b0;
  int ready_cnt0 = 0, ready_cnt1 = 0;
  int grants0 = 0, grants1 = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] mem_model [int];

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous data memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) mem_model[int'(mem_addr)] = mem_wdata;
    if (mem_rd) mem_rdata <= mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : '0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_strobes", {mem_rd, mem_wr}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_owner", owner, 0);
    check("rst_ready", {p0_ready, p1_ready}, 0);
    check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    rst = 1'b0;
  endtask

  // Random requester: holds each request until ready, then moves on.
  task automatic drive_rand(input int port, input int end_cyc);
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int waited;
    while (cyc < end_cyc) begin
      repeat ($urandom_range(0, 3)) tick();
      we = 1'($urandom_range(0, 1));
      a  = AW'(64 + $urandom_range(0, 15));
      d  = DW'($urandom);
      set_req(port, 1'b1, we, a, d);
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!((port == 0) ? p0_ready : p1_ready) && waited < 20);
      if (!((port == 0) ? p0_ready : p1_ready)) begin
        check(port == 0 ? "p0_grant_timeout" : "p1_grant_timeout", waited, 0);
      end else begin
        if (port == 0) grants0++; else grants1++;
        if (we) ref_mem[int'(a)] = d;
        else if (port == 0) exp_q0.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0);
        else exp_q1.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0);
      end
      tick();
      set_req(port, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", {31'b0, mem_rd & mem_wr}, 0);
      if (sb_en) begin
        if (p0_ready) begin ready_cnt0++; check("p0_ready_without_req", p0_req, 1); end
        if (p1_ready) begin ready_cnt1++; check("p1_ready_without_req", p1_req, 1); end
        if (p0_rvalid) begin
          check("p0_rvalid_pending", exp_q0.size() != 0, 1);
          if (exp_q0.size() != 0) check("p0_rand_rdata", p0_rdata, exp_q0.pop_front());
        end else check("p0_rdata_idle", p0_rdata, 0);
        if (p1_rvalid) begin
          check("p1_rvalid_pending", exp_q1.size() != 0, 1);
          if (exp_q1.size() != 0) check("p1_rand_rdata", p1_rdata, exp_q1.pop_front());
        end else check("p1_rdata_idle", p1_rdata, 0);
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];
  int   exp_order [4];

  initial begin
    vec[0] = '{0, 1'b1, 11'h005, 16'hBEEF, 16'h0000};
    vec[1] = '{1, 1'b0, 11'h005, 16'h0000, 16'hBEEF};
    vec[2] = '{1, 1'b1, 11'h7FF, 16'h1234, 16'h0000};
    vec[3] = '{0, 1'b0, 11'h7FF, 16'h0000, 16'h1234};
    vec[4] = '{0, 1'b1, 11'h000, 16'hA5A5, 16'h0000};
    vec[5] = '{1, 1'b1, 11'h005, 16'h0F0F, 16'h0000};
    vec[6] = '{0, 1'b0, 11'h005, 16'h0000, 16'h0F0F};
    vec[7] = '{1, 1'b0, 11'h000, 16'h0000, 16'hA5A5};
    vec[8] = '{0, 1'b0, 11'h123, 16'h0000, 16'h0000};
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    do_reset();

    // Single-port accesses: ready at T+1, read data at T+2, busy for 1 or 2 cycles.
    for (int i = 0; i < NV; i++) begin
      set_req(vec[i].port, 1'b1, vec[i].we, vec[i].addr, vec[i].wdata);
      tick();
      check("v_p0_ready", p0_ready, vec[i].port == 0);
      check("v_p1_ready", p1_ready, vec[i].port == 1);
      check("v_mem_wr", mem_wr, vec[i].we);
      check("v_mem_rd", mem_rd, !vec[i].we);
      check("v_mem_addr", mem_addr, vec[i].addr);
      if (vec[i].we) check("v_mem_wdata", mem_wdata, vec[i].wdata);
      check("v_owner", owner, vec[i].port);
      check("v_busy_access", busy, 1);
      tick();
      set_req(vec[i].port, 1'b0, 1'b0, '0, '0);
      if (!vec[i].we) begin
        check("v_p0_rvalid", p0_rvalid, vec[i].port == 0);
        check("v_p1_rvalid", p1_rvalid, vec[i].port == 1);
        check("v_rdata", vec[i].port == 0 ? p0_rdata : p1_rdata, vec[i].exp_rdata);
        check("v_other_rdata", vec[i].port == 0 ? p1_rdata : p0_rdata, 0);
        check("v_resp_strobes", {mem_rd, mem_wr}, 0);
        tick();
      end
      check("v_busy_done", busy, 0);
      check("v_idle_strobes", {mem_rd, mem_wr, p0_ready, p1_ready}, 0);
    end

    // Contention with both requests held for four grants.
    do_reset();
    set_req(0, 1'b1, 1'b1, 11'h100, 16'h1111);
    set_req(1, 1'b1, 1'b1, 11'h101, 16'h2222);
    for (int g = 0; g < 4; g++) begin
      int waited;
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(p0_ready || p1_ready) && waited < 10);
      check("arb_grant_seen", p0_ready | p1_ready, 1);
      check("arb_one_ready", p0_ready & p1_ready, 0);
      check("arb_order", p1_ready, exp_order[g]);
      check("arb_owner", owner, exp_order[g]);
    end
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("arb_idle", busy, 0);

    // Reset during RESP of a port 0 read; pointer must come back to port 0.
    set_req(0, 1'b1, 1'b0, 11'h005, '0);
    tick();
    check("rr_p0_ready", p0_ready, 1);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    check("rr_in_resp", p0_rvalid, 1);
    rst = 1'b1;
    tick();
    check("rr_busy", busy, 0);
    check("rr_rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rr_strobes", {mem_rd, mem_wr}, 0);
    check("rr_rdata", p0_rdata, 0);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 11'h110, 16'h3333);
    set_req(1, 1'b1, 1'b1, 11'h111, 16'h4444);
    tick();
    check("rr_first_p0", p0_ready, 1);
    check("rr_first_not_p1", p1_ready, 0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    check("rr_then_p1", p1_ready, 1);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Random two-port mix against the reference memory.
    sb_en = 1'b1;
    begin
      int end_cyc;
      end_cyc = cyc + 10000;
      fork
        drive_rand(0, end_cyc);
        drive_rand(1, end_cyc);
      join
    end
    repeat (6) tick();
    sb_en = 1'b0;
    check("p0_reads_drained", exp_q0.size(), 0);
    check("p1_reads_drained", exp_q1.size(), 0);
    check("p0_ready_per_grant", ready_cnt0, grants0);
    check("p1_ready_per_grant", ready_cnt1, grants1);
    check("p0_progress", grants0 > 100, 1);
    check("p1_progress", grants1 > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
